ysyx_22040125_halt_ctrl: RTL and testbench
==========================================

# ysyx_22040125_halt_ctrl

Halt/trap sequencer for the ysyx_22040125 RV64 core. When an `ebreak` issues from decode, the block stalls fetch and tracks in-flight instructions. Once the `ebreak` itself retires, it enters a sticky halt state and reports the trap PC, instruction and exit code (`a0`) to the simulation harness. It replaces fixed-depth `ebreak` delay chains with occupancy-aware, flush-aware sequencing.

## Interface
- `IW`, default 3: width of the in-flight counter; max tracked in-flight instructions = 2^IW−1.
- `TMO`, default 255: drain timeout in cycles; legal range 1..65535.
- `clk`  in  1  core clock.
- `rst`  in  1  reset, synchronous, active-low.
- `issue_valid`  in  1  one instruction leaves decode into execute this cycle.
- `issue_ebreak`  in  1  issuing instruction is `ebreak`; qualified by `issue_valid`.
- `issue_pc`  in  64  PC of issuing instruction.
- `issue_inst`  in  32  encoding of issuing instruction.
- `retire_valid`  in  1  one instruction completes writeback this cycle, in program order.
- `flush`  in  1  writeback redirect; all unretired instructions are discarded.
- `a0_value`  in  64  current architectural `a0` (regfile bypass-correct view).
- `fetch_stall`  out  1  blocks fetch/issue.
- `halt`  out  1  sticky halted.
- `halt_pc`  out  64  PC of the trapping `ebreak`.
- `halt_inst`  out  32  encoding of the trapping `ebreak`.
- `halt_code`  out  64  `a0` at retire, or all-ones on timeout.
- `good_trap`  out  1  halted normally with `halt_code`==0.
- `timeout`  out  1  halted because the drain timed out.
- `inflight`  out  IW  current in-flight count.

## Operation
- FSM states: RUN, DRAIN, HALT. Reset state is RUN.
- In-flight counter:
  - Next value = cnt + (issue_valid && state!=HALT) − (retire_valid && cnt!=0).
  - Retire at cnt==0 is ignored (no underflow).
  - Issue at cnt==2^IW−1 saturates; the counter does not change.
  - `flush` forces the next count to 0 in any state, overriding issue and retire.
- RUN → DRAIN when `issue_valid && issue_ebreak`.
  - Captures `issue_pc` and `issue_inst` into `halt_pc` and `halt_inst`.
  - Loads `epos` = the post-issue count; this is the `ebreak`'s depth from the head.
- DRAIN:
  - Each `retire_valid` decrements `epos`.
  - When `retire_valid` occurs with `epos`==1, the `ebreak` retires: capture `a0_value` into `halt_code`, then → HALT.
  - `flush` without that retire → RUN; captured `halt_pc`/`halt_inst` are cleared to 0.
  - `flush` in the same cycle as the `ebreak` retire: the retire wins → HALT.
  - Drain counter counts cycles in DRAIN. When it reaches TMO without the retire → HALT with `timeout`=1 and `halt_code`=all-ones.
- HALT:
  - Terminal until `rst` is low.
  - `issue_valid` and `retire_valid` are ignored; `flush` still zeros the count.
  - `good_trap` = (`halt_code`==0) && !`timeout`.
- A second `issue_ebreak` during DRAIN is not expected, because fetch is stalled. If it occurs, it is counted as an ordinary issue and not captured.

## Timing
- `fetch_stall` = (`issue_valid && issue_ebreak` && state==RUN) || state!=RUN.
  - Combinational, so the instruction after the `ebreak` is blocked in the issue cycle itself.
  - All other outputs are registered.
- `halt` rises the cycle after the `ebreak` retire cycle; that is, `halt` latency = 1 cycle after the retire cycle.
- Timeout: `halt` rises the cycle after the drain counter equals TMO, i.e. TMO+1 cycles after entering DRAIN.
- `inflight` reflects the registered count.
- Reset: while `rst`=0 at a clock edge, all outputs are 0 and state is RUN. This applies mid-DRAIN or mid-HALT; `fetch_stall` is 0 once reset is applied.

## Test plan
- Empty pipe, issue `ebreak` with pc=0x80000010, inst=0x00100073, `a0`=0, then one retire 3 cycles later → `fetch_stall` high from the issue cycle; `halt` high the cycle after the retire; `good_trap`=1; `halt_pc`=0x80000010.
- Three older instructions in flight, then `ebreak` (count=4), `a0`=0x2A; retire one per cycle → `halt` only after the 4th retire; `halt_code`=0x2A; `good_trap`=0.
- `ebreak` issued with 2 older in flight; `flush` with the 1st retire → state RUN, `fetch_stall`=0, `inflight`=0, `halt_pc`=0; no halt.
- TMO=8, `ebreak` issued, no retires → `halt`=1 and `timeout`=1 on cycle 9 after issue; `halt_code`=0xFFFF_FFFF_FFFF_FFFF.
- Simultaneous issue and retire at cnt=2 → cnt stays 2; retire at cnt=0 → stays 0; IW=3 with 8 issues → saturates at 7.
- Assert `rst`=0 while halted → next cycle all outputs 0; a fresh `ebreak` sequence then halts normally.

Source files
------------

// File: rtl/ysyx_22040125_halt_ctrl.sv
// Halt/trap sequencer: stalls fetch on ebreak, waits for the ebreak to retire
// (or the drain to time out), then latches a sticky halt with PC/inst/a0.
module ysyx_22040125_halt_ctrl #(
  parameter int IW  = 3,
  parameter int TMO = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic          issue_ebreak,
  input  logic [63:0]   issue_pc,
  input  logic [31:0]   issue_inst,
  input  logic          retire_valid,
  input  logic          flush,
  input  logic [63:0]   a0_value,
  output logic          fetch_stall,
  output logic          halt,
  output logic [63:0]   halt_pc,
  output logic [31:0]   halt_inst,
  output logic [63:0]   halt_code,
  output logic          good_trap,
  output logic          timeout,
  output logic [IW-1:0] inflight
);

  localparam logic [1:0]    S_RUN   = 2'd0;
  localparam logic [1:0]    S_DRAIN = 2'd1;
  localparam logic [1:0]    S_HALT  = 2'd2;
  localparam logic [IW-1:0] CNT_MAX = {IW{1'b1}};
  localparam logic [IW-1:0] CNT_ONE = {{(IW-1){1'b0}}, 1'b1};
  localparam logic [15:0]   TMO_V   = 16'(TMO);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d, cnt_nf;
  logic [IW-1:0] epos_q, epos_d;
  logic [15:0]   dcnt_q, dcnt_d;
  logic [63:0]   halt_pc_q, halt_pc_d;
  logic [31:0]   halt_inst_q, halt_inst_d;
  logic [63:0]   halt_code_q, halt_code_d;
  logic          timeout_q, timeout_d;

  logic          inc, dec, ebreak_go, eb_retire;
  logic [IW:0]   cnt_sum;

  assign ebreak_go = issue_valid && issue_ebreak && (state_q == S_RUN);
  assign eb_retire = (state_q == S_DRAIN) && retire_valid && (epos_q == CNT_ONE);

  // One extra bit catches the overflow of an issue at full occupancy so it clamps.
  always_comb begin
    inc     = issue_valid && (state_q != S_HALT);
    dec     = retire_valid && (cnt_q != '0) && (state_q != S_HALT);
    cnt_sum = {1'b0, cnt_q} + {{IW{1'b0}}, inc} - {{IW{1'b0}}, dec};
    cnt_nf  = cnt_sum[IW] ? CNT_MAX : cnt_sum[IW-1:0];
    cnt_d   = flush ? '0 : cnt_nf;
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d     = state_q;
    epos_d      = epos_q;
    dcnt_d      = dcnt_q;
    halt_pc_d   = halt_pc_q;
    halt_inst_d = halt_inst_q;
    halt_code_d = halt_code_q;
    timeout_d   = timeout_q;
    case (state_q)
      S_RUN: begin
        if (ebreak_go) begin
          state_d     = S_DRAIN;
          halt_pc_d   = issue_pc;
          halt_inst_d = issue_inst;
          epos_d      = cnt_nf;
          dcnt_d      = 16'd1;
        end
      end
      S_DRAIN: begin
        if (retire_valid) epos_d = epos_q - CNT_ONE;
        dcnt_d = dcnt_q + 16'd1;
        // Retire of the ebreak beats a same-cycle flush and the timeout.
        if (eb_retire) begin
          state_d     = S_HALT;
          halt_code_d = a0_value;
        end else if (flush) begin
          state_d     = S_RUN;
          halt_pc_d   = '0;
          halt_inst_d = '0;
        end else if (dcnt_q == TMO_V) begin
          state_d     = S_HALT;
          timeout_d   = 1'b1;
          halt_code_d = '1;
        end
      end
      S_HALT: ;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      state_q     <= S_RUN;
      cnt_q       <= '0;
      epos_q      <= '0;
      dcnt_q      <= '0;
      halt_pc_q   <= '0;
      halt_inst_q <= '0;
      halt_code_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      epos_q      <= epos_d;
      dcnt_q      <= dcnt_d;
      halt_pc_q   <= halt_pc_d;
      halt_inst_q <= halt_inst_d;
      halt_code_q <= halt_code_d;
      timeout_q   <= timeout_d;
    end
  end

  // Stall is combinational so the instruction behind the ebreak never issues.
  assign fetch_stall = rst && (ebreak_go || (state_q != S_RUN));
  assign halt        = (state_q == S_HALT);
  assign halt_pc     = halt_pc_q;
  assign halt_inst   = halt_inst_q;
  assign halt_code   = halt_code_q;
  assign timeout     = timeout_q;
  assign good_trap   = halt && (halt_code_q == '0) && !timeout_q;
  assign inflight    = cnt_q;

endmodule

// File: tb/tb_ysyx_22040125_halt_ctrl.sv
// Bench for the halt sequencer: directed scenarios plus random traffic, all
// compared each cycle against a queue-based model of the in-flight window.
module tb_ysyx_22040125_halt_ctrl;
  localparam int IW  = 3;
  localparam int TMO = 8;
  localparam int MAX = (1 << IW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          issue_valid, issue_ebreak, retire_valid, flush;
  logic [63:0]   issue_pc, a0_value;
  logic [31:0]   issue_inst;
  logic          fetch_stall, halt, good_trap, timeout;
  logic [63:0]   halt_pc, halt_code;
  logic [31:0]   halt_inst;
  logic [IW-1:0] inflight;

  always #5 clk = ~clk;

  ysyx_22040125_halt_ctrl #(.IW(IW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ebreak(issue_ebreak),
    .issue_pc(issue_pc), .issue_inst(issue_inst),
    .retire_valid(retire_valid), .flush(flush), .a0_value(a0_value),
    .fetch_stall(fetch_stall), .halt(halt), .halt_pc(halt_pc),
    .halt_inst(halt_inst), .halt_code(halt_code), .good_trap(good_trap),
    .timeout(timeout), .inflight(inflight)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: each in-flight instruction is a queue entry; 1 marks the tracked ebreak.
  bit          m_q[$];
  bit          m_drain, m_halt, m_to;
  int          m_dcyc;
  logic [63:0] m_pc, m_code;
  logic [31:0] m_inst;

  bit iv, ie, rv, fl;
  int hold;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  task automatic model_edge();
    bit ret_eb, was_drain;
    ret_eb    = 1'b0;
    was_drain = m_drain;
    if (!rst) begin
      m_q.delete();
      m_drain = 0; m_halt = 0; m_to = 0; m_dcyc = 0;
      m_pc = '0; m_inst = '0; m_code = '0;
      return;
    end
    if (m_halt) begin
      if (flush) m_q.delete();
      return;
    end
    if (retire_valid && m_q.size() > 0) ret_eb = m_q.pop_front();
    if (issue_valid) begin
      if (!was_drain && issue_ebreak) begin
        m_q.push_back(1'b1);
        m_drain = 1; m_dcyc = 1; m_pc = issue_pc; m_inst = issue_inst;
      end else if (m_q.size() < MAX) begin
        m_q.push_back(1'b0);
      end
    end
    if (was_drain) begin
      if (ret_eb) begin
        m_drain = 0; m_halt = 1; m_code = a0_value;
      end else if (flush) begin
        m_drain = 0; m_pc = '0; m_inst = '0;
      end else if (m_dcyc == TMO) begin
        m_drain = 0; m_halt = 1; m_to = 1; m_code = '1;
      end else begin
        m_dcyc++;
      end
    end
    if (flush) m_q.delete();
  endtask

  task automatic cycle();
    logic exp_fs;
    #1;
    exp_fs = rst && ((issue_valid && issue_ebreak && !m_drain && !m_halt) || m_drain || m_halt);
    check("fetch_stall", 64'(fetch_stall), 64'(exp_fs));
    @(posedge clk);
    model_edge();
    #1;
    check("halt",      64'(halt),      64'(m_halt));
    check("timeout",   64'(timeout),   64'(m_to));
    check("halt_pc",   halt_pc,        m_pc);
    check("halt_inst", 64'(halt_inst), 64'(m_inst));
    check("halt_code", halt_code,      m_code);
    check("good_trap", 64'(good_trap), 64'(m_halt && m_code == 64'd0 && !m_to));
    check("inflight",  64'(inflight),  64'(m_q.size()));
  endtask

  task automatic drive(input bit d_iv, input bit d_ie, input bit d_rv, input bit d_fl);
    issue_valid = d_iv; issue_ebreak = d_ie; retire_valid = d_rv; flush = d_fl;
    cycle();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; issue_valid = 0; issue_ebreak = 0; retire_valid = 0; flush = 0;
    issue_pc = '0; issue_inst = '0; a0_value = '0;
    #2;
    do_reset();
    check("rst_inflight", 64'(inflight), 64'd0);
    check("rst_halt", 64'(halt), 64'd0);

    // Empty pipe, ebreak, retire three cycles later.
    issue_pc = 64'h8000_0010; issue_inst = 32'h0010_0073; a0_value = 64'd0;
    drive(1, 1, 0, 0);
    check("A_stall", 64'(fetch_stall), 64'd1);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    check("A_nohalt", 64'(halt), 64'd0);
    drive(0, 0, 1, 0);
    check("A_halt", 64'(halt), 64'd1);
    check("A_good", 64'(good_trap), 64'd1);
    check("A_pc", halt_pc, 64'h8000_0010);
    check("A_inst", 64'(halt_inst), 64'h0010_0073);

    // Three older instructions ahead of the ebreak.
    do_reset();
    a0_value = 64'h2A; issue_pc = 64'h8000_0040;
    repeat (3) drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    check("B_inflight", 64'(inflight), 64'd4);
    repeat (3) drive(0, 0, 1, 0);
    check("B_nohalt", 64'(halt), 64'd0);
    drive(0, 0, 1, 0);
    check("B_halt", 64'(halt), 64'd1);
    check("B_code", halt_code, 64'h2A);
    check("B_good", 64'(good_trap), 64'd0);

    // Flush on the first retire cancels the drain.
    do_reset();
    issue_pc = 64'h8000_0080;
    repeat (2) drive(1, 0, 0, 0);
    drive(1, 1, 0, 0);
    drive(0, 0, 1, 1);
    check("C_stall", 64'(fetch_stall), 64'd0);
    check("C_inflight", 64'(inflight), 64'd0);
    check("C_pc", halt_pc, 64'd0);
    repeat (3) drive(0, 0, 0, 0);
    check("C_nohalt", 64'(halt), 64'd0);

    // Drain timeout with TMO=8: halt on cycle 9 after issue.
    do_reset();
    issue_pc = 64'h8000_00C0;
    drive(1, 1, 0, 0);
    repeat (7) drive(0, 0, 0, 0);
    check("D_nohalt8", 64'(halt), 64'd0);
    drive(0, 0, 0, 0);
    check("D_halt9", 64'(halt), 64'd1);
    check("D_timeout", 64'(timeout), 64'd1);
    check("D_code", halt_code, 64'hFFFF_FFFF_FFFF_FFFF);
    check("D_good", 64'(good_trap), 64'd0);

    // Counter corners.
    do_reset();
    repeat (2) drive(1, 0, 0, 0);
    check("E_cnt2", 64'(inflight), 64'd2);
    drive(1, 0, 1, 0);
    check("E_issue_retire", 64'(inflight), 64'd2);
    repeat (2) drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    check("E_no_underflow", 64'(inflight), 64'd0);
    repeat (8) drive(1, 0, 0, 0);
    check("E_saturate", 64'(inflight), 64'd7);

    // Reset while halted, then a fresh sequence.
    drive(0, 0, 0, 1);
    issue_pc = 64'h8000_0100; a0_value = 64'd7;
    drive(1, 1, 0, 0);
    drive(0, 0, 1, 0);
    check("F_halt", 64'(halt), 64'd1);
    rst = 1'b0;
    drive(1, 1, 1, 0);
    check("F_rst_stall", 64'(fetch_stall), 64'd0);
    check("F_rst_halt", 64'(halt), 64'd0);
    check("F_rst_pc", halt_pc, 64'd0);
    check("F_rst_code", halt_code, 64'd0);
    check("F_rst_inflight", 64'(inflight), 64'd0);
    rst = 1'b1;
    a0_value = 64'd0; issue_pc = 64'h8000_0200;
    drive(1, 1, 0, 0);
    drive(0, 0, 1, 0);
    check("F_rehalt", 64'(halt), 64'd1);
    check("F_regood", 64'(good_trap), 64'd1);
    check("F_repc", halt_pc, 64'h8000_0200);

    // Random traffic.
    do_reset();
    hold = 0;
    for (int i = 0; i < 600; i++) begin
      if (m_halt) begin
        hold++;
        if (hold > 2) begin
          rst  = 1'b0;
          hold = 0;
        end
        drive(0, 0, 0, $urandom_range(0, 3) == 0);
        rst = 1'b1;
      end else begin
        iv = 1'($urandom_range(0, 1));
        rv = 1'($urandom_range(0, 1));
        ie = iv && ($urandom_range(0, 3) == 0) && (m_drain || m_q.size() < MAX);
        fl = ($urandom_range(0, 15) == 0) && !(iv && ie && !m_drain);
        issue_pc   = {$urandom, $urandom};
        issue_inst = $urandom;
        a0_value   = ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom};
        drive(iv, ie, rv, fl);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
